// File: rtl/gpr_file_mp.sv
// Multi-port general-purpose register file with write-to-read bypass, optional
// registered read stage and a per-register pending-write scoreboard.
module gpr_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 2,
  parameter int REG_READ   = 0,
  parameter int ZERO_REG   = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_WRITE-1:0]             wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wr_data,
  input  logic [NUM_READ-1:0]              rd_en,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
  output logic [NUM_READ-1:0]              rd_pending,
  input  logic                             sb_set_en,
  input  logic [ADDR_WIDTH-1:0]            sb_set_addr,
  input  logic                             sb_flush
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]       regs_q [DEPTH];
  logic [DATA_WIDTH-1:0]       regs_d [DEPTH];
  logic [DEPTH-1:0]            pending_q;
  logic [DEPTH-1:0]            pending_d;
  logic [ADDR_WIDTH-1:0]       wa_s [NUM_WRITE];
  logic [DATA_WIDTH-1:0]       wd_s [NUM_WRITE];
  logic [ADDR_WIDTH-1:0]       ra_s [NUM_READ];
  logic [DATA_WIDTH-1:0]       rd_byp_s [NUM_READ];
  logic [NUM_READ-1:0]         rd_hit_s;
  logic [NUM_READ-1:0]         rd_pend_s;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_val_s;
  logic [NUM_READ*DATA_WIDTH-1:0] rd_out_s;

  function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_WIDTH{1'b0}});
  endfunction

  for (genvar k = 0; k < NUM_WRITE; k++) begin : g_wr_unpack
    assign wa_s[k] = wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd_s[k] = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd_unpack
    assign ra_s[i] = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Next-state of storage and scoreboard; later ports overwrite earlier ones, and a
  // scoreboard set is applied after write clears so a newer producer keeps the bit.
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (wr_en[k] && !is_zero_reg(wa_s[k])) begin
        regs_d[wa_s[k]]    = wd_s[k];
        pending_d[wa_s[k]] = 1'b0;
      end else begin
        regs_d[wa_s[k]] = regs_d[wa_s[k]];
      end
    end
    if (sb_flush) begin
      pending_d = {DEPTH{1'b0}};
    end else if (sb_set_en && !is_zero_reg(sb_set_addr)) begin
      pending_d[sb_set_addr] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // Per-port read resolution with bypass from this cycle's writes.
  always_comb begin
    rd_val_s  = {(NUM_READ*DATA_WIDTH){1'b0}};
    rd_pend_s = {NUM_READ{1'b0}};
    rd_hit_s  = {NUM_READ{1'b0}};
    for (int i = 0; i < NUM_READ; i++) begin
      rd_byp_s[i] = regs_q[ra_s[i]];
      for (int k = 0; k < NUM_WRITE; k++) begin
        if (wr_en[k] && (wa_s[k] == ra_s[i])) begin
          rd_hit_s[i] = 1'b1;
          rd_byp_s[i] = wd_s[k];
        end else begin
          rd_hit_s[i] = rd_hit_s[i];
        end
      end
      if (!rd_en[i] || is_zero_reg(ra_s[i])) begin
        rd_val_s[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end else begin
        rd_val_s[i*DATA_WIDTH +: DATA_WIDTH] = rd_byp_s[i];
      end
      rd_pend_s[i] = rd_en[i] && pending_q[ra_s[i]] && !rd_hit_s[i];
    end
  end

  if (REG_READ != 0) begin : g_reg_read
    logic [NUM_READ*DATA_WIDTH-1:0] rd_data_q;
    logic [NUM_READ*DATA_WIDTH-1:0] rd_data_d;

    always_comb rd_data_d = rd_val_s;

    // Read pipeline register.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rd_data_q <= {(NUM_READ*DATA_WIDTH){1'b0}};
      end else begin
        rd_data_q <= rd_data_d;
      end
    end

    assign rd_out_s = rd_data_q;
  end else begin : g_comb_read
    assign rd_out_s = rd_val_s;
  end

  // Storage and scoreboard state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        regs_q[j] <= {DATA_WIDTH{1'b0}};
      end
      pending_q <= {DEPTH{1'b0}};
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  // Outputs read as zero whenever reset is held.
  always_comb begin
    if (reset) begin
      rd_data    = rd_out_s;
      rd_pending = rd_pend_s;
    end else begin
      rd_data    = {(NUM_READ*DATA_WIDTH){1'b0}};
      rd_pending = {NUM_READ{1'b0}};
    end
  end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Scoreboard bench for gpr_file_mp: a combinational-read and a registered-read
// instance share stimulus and are checked against a reference model.
module tb_gpr_file_mp;

  logic        clock;
  logic        reset;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr;
  logic        sb_flush;
  logic [63:0] c_rd_data;
  logic [1:0]  c_rd_pending;
  logic [63:0] r_rd_data;
  logic [1:0]  r_rd_pending;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [32];
  logic [31:0] pend;
  logic [63:0] q_data [$];
  logic [1:0]  q_pend [$];
  logic [63:0] q_rr [$];

  gpr_file_mp #(.REG_READ(0)) u_dut_comb (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(c_rd_data), .rd_pending(c_rd_pending),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush)
  );

  gpr_file_mp #(.REG_READ(1)) u_dut_reg (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(r_rd_data), .rd_pending(r_rd_pending),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .sb_flush(sb_flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle();
    wr_en = 2'b00; wr_addr = 10'd0; wr_data = 64'd0;
    rd_en = 2'b00; rd_addr = 10'd0;
    sb_set_en = 1'b0; sb_set_addr = 5'd0; sb_flush = 1'b0;
  endtask

  task automatic set_wr(input int k, input logic [4:0] a, input logic [31:0] d);
    wr_en[k] = 1'b1; wr_addr[k*5 +: 5] = a; wr_data[k*32 +: 32] = d;
  endtask

  task automatic set_rd(input int i, input logic [4:0] a);
    rd_en[i] = 1'b1; rd_addr[i*5 +: 5] = a;
  endtask

  task automatic model_reset();
    for (int j = 0; j < 32; j++) mem[j] = 32'd0;
    pend = 32'd0;
    q_data.delete(); q_pend.delete(); q_rr.delete();
    q_rr.push_back(64'd0);
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      logic [4:0] a;
      a = wr_addr[k*5 +: 5];
      if (wr_en[k] && a != 5'd0) begin
        mem[a]  = wr_data[k*32 +: 32];
        pend[a] = 1'b0;
      end
    end
    if (sb_set_en && sb_set_addr != 5'd0) pend[sb_set_addr] = 1'b1;
    if (sb_flush) pend = 32'd0;
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic cycle();
    logic [63:0] exp_d;
    logic [1:0]  exp_p;
    logic [63:0] got_rr;
    logic [1:0]  got_p;
    for (int i = 0; i < 2; i++) begin
      logic [4:0]  a;
      logic [31:0] v;
      logic        hit;
      a = rd_addr[i*5 +: 5];
      hit = 1'b0;
      v = mem[a];
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k] && wr_addr[k*5 +: 5] == a) begin
          hit = 1'b1;
          v = wr_data[k*32 +: 32];
        end
      end
      if (!rd_en[i] || a == 5'd0) v = 32'd0;
      exp_d[i*32 +: 32] = v;
      exp_p[i] = rd_en[i] && pend[a] && !hit;
    end
    q_data.push_back(exp_d);
    q_pend.push_back(exp_p);
    @(negedge clock);
    check_eq("comb_rd_data", c_rd_data, q_data.pop_front());
    got_p = q_pend.pop_front();
    check_eq("comb_rd_pending", {62'd0, c_rd_pending}, {62'd0, got_p});
    check_eq("reg_rd_pending", {62'd0, r_rd_pending}, {62'd0, got_p});
    got_rr = q_rr.pop_front();
    check_eq("reg_rd_data", r_rd_data, got_rr);
    q_rr.push_back(exp_d);
    @(posedge clock);
    model_update();
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    model_reset();
    set_rd(0, 5'd5); set_rd(1, 5'd9);
    #3;
    check_eq("in_reset_comb_data", c_rd_data, 64'd0);
    check_eq("in_reset_reg_data", r_rd_data, 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    idle();

    // 1: all addresses read zero after reset
    for (int j = 0; j < 16; j++) begin
      set_rd(0, 5'(2*j)); set_rd(1, 5'(2*j + 1));
      cycle();
    end

    // 2: single write then read on both ports
    set_wr(0, 5'd5, 32'hDEADBEEF); cycle();
    set_rd(0, 5'd5); set_rd(1, 5'd5); cycle();

    // 3: collision, higher port wins, bypass and stored value
    set_wr(0, 5'd7, 32'h1111); set_wr(1, 5'd7, 32'h2222); set_rd(0, 5'd7); cycle();
    set_rd(1, 5'd7); cycle();
    set_wr(0, 5'd8, 32'h3333); set_wr(1, 5'd8, 32'h4444); set_rd(1, 5'd8); cycle();

    // 4: zero register
    set_wr(1, 5'd0, 32'hFFFFFFFF); set_rd(0, 5'd0); cycle();
    set_rd(0, 5'd0); sb_set_en = 1'b1; sb_set_addr = 5'd0; cycle();
    set_rd(0, 5'd0); set_rd(1, 5'd0); cycle();

    // 5: scoreboard set, clear by write, set wins over clear
    sb_set_en = 1'b1; sb_set_addr = 5'd9; cycle();
    set_rd(0, 5'd9); cycle();
    set_rd(1, 5'd9); set_wr(0, 5'd9, 32'h42); cycle();
    set_rd(0, 5'd9); cycle();
    sb_set_en = 1'b1; sb_set_addr = 5'd9; set_wr(1, 5'd9, 32'h43); cycle();
    set_rd(0, 5'd9); set_rd(1, 5'd9); cycle();
    set_rd(0, 5'd9); rd_en[0] = 1'b0; cycle();

    // flush clears everything and beats a simultaneous set
    sb_set_en = 1'b1; sb_set_addr = 5'd10; cycle();
    sb_set_en = 1'b1; sb_set_addr = 5'd11; set_rd(0, 5'd10); cycle();
    sb_flush = 1'b1; sb_set_en = 1'b1; sb_set_addr = 5'd12; set_rd(0, 5'd11); cycle();
    set_rd(0, 5'd12); set_rd(1, 5'd9); cycle();

    // mixed traffic
    for (int n = 0; n < 60; n++) begin
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 1) == 1) set_wr(k, 5'($urandom_range(0, 7)), $urandom);
      for (int i = 0; i < 2; i++)
        if ($urandom_range(0, 3) != 0) set_rd(i, 5'($urandom_range(0, 7)));
      sb_set_en   = ($urandom_range(0, 2) == 0);
      sb_set_addr = 5'($urandom_range(0, 7));
      sb_flush    = ($urandom_range(0, 15) == 0);
      cycle();
    end

    // 6: registered read latency, then reset pulse mid-stream
    set_wr(0, 5'd3, 32'hA5); set_rd(0, 5'd3); cycle();
    set_rd(0, 5'd3); sb_set_en = 1'b1; sb_set_addr = 5'd3; cycle();
    set_rd(0, 5'd3); set_rd(1, 5'd3);
    reset = 1'b0;
    #1;
    check_eq("reset_pulse_reg_data", r_rd_data, 64'd0);
    check_eq("reset_pulse_comb_data", c_rd_data, 64'd0);
    check_eq("reset_pulse_pending", {62'd0, c_rd_pending}, 64'd0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    set_rd(0, 5'd3); set_rd(1, 5'd5); cycle();
    set_rd(0, 5'd3); cycle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
